// File: rtl/vec_wb_sequencer_if.sv
// Writeback-stage bus: MEM/WB entry handshake on one side, scalar/vector RF write ports on the other.
interface vec_wb_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 8,
  parameter int LPC    = 2,
  parameter int ADDR_W = 5
);
  localparam int LBW = (LANES > 1) ? $clog2(LANES) : 1;

  logic                    in_valid;
  logic                    in_ready;
  logic                    reg_write;
  logic                    is_vec;
  logic                    mem_to_reg;
  logic [ADDR_W-1:0]       write_addr;
  logic [DATA_W-1:0]       alu_result;
  logic [DATA_W-1:0]       read_data;
  logic [LANES*DATA_W-1:0] lane_data;
  logic                    srf_we;
  logic [ADDR_W-1:0]       srf_addr;
  logic [DATA_W-1:0]       srf_wdata;
  logic                    vrf_we;
  logic [ADDR_W-1:0]       vrf_addr;
  logic [LBW-1:0]          vrf_lane_base;
  logic [LPC*DATA_W-1:0]   vrf_wdata;
  logic                    busy;

  modport master (
    output in_valid, reg_write, is_vec, mem_to_reg, write_addr, alu_result, read_data, lane_data,
    input  in_ready, srf_we, srf_addr, srf_wdata, vrf_we, vrf_addr, vrf_lane_base, vrf_wdata, busy
  );

  modport slave (
    input  in_valid, reg_write, is_vec, mem_to_reg, write_addr, alu_result, read_data, lane_data,
    output in_ready, srf_we, srf_addr, srf_wdata, vrf_we, vrf_addr, vrf_lane_base, vrf_wdata, busy
  );
endinterface

// File: rtl/vec_wb_sequencer.sv
// Writeback sequencer: scalar results in one beat, vector results drained LPC lanes per beat,
// stalling the pipeline (in_ready low) while a burst is in flight.
module vec_wb_sequencer #(
  parameter int DATA_W = 32,
  parameter int LANES  = 8,
  parameter int LPC    = 2,
  parameter int ADDR_W = 5
) (
  input logic              clk,
  input logic              rst,
  vec_wb_sequencer_if.slave wb
);
  localparam int BEATS = LANES / LPC;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LBW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int BW    = LPC * DATA_W;

  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t            state_r, state_s;
  logic [CW-1:0]     beat_r, beat_s, beat_nx_s;
  logic [BW-1:0]     buf_r [BEATS];
  logic              buf_load_s;
  logic              last_s, in_ready_s, accept_s;
  logic              srf_we_r, srf_we_s;
  logic [ADDR_W-1:0] srf_addr_r, srf_addr_s;
  logic [DATA_W-1:0] srf_wdata_r, srf_wdata_s;
  logic              vrf_we_r, vrf_we_s;
  logic [ADDR_W-1:0] vrf_addr_r, vrf_addr_s;
  logic [LBW-1:0]    vrf_base_r, vrf_base_s;
  logic [BW-1:0]     vrf_wdata_r, vrf_wdata_s;

  // The last beat is the only burst cycle that may accept, giving zero-bubble back-to-back work.
  assign last_s     = (state_r == BURST) && (beat_r == CW'(BEATS - 1));
  assign in_ready_s = !rst && ((state_r == IDLE) || last_s);
  assign accept_s   = wb.in_valid && in_ready_s;
  assign beat_nx_s  = beat_r + CW'(1);

  // Next-state and next-output computation.
  always_comb begin
    state_s     = state_r;
    beat_s      = beat_r;
    buf_load_s  = 1'b0;
    srf_we_s    = 1'b0;
    srf_addr_s  = srf_addr_r;
    srf_wdata_s = srf_wdata_r;
    vrf_we_s    = 1'b0;
    vrf_addr_s  = vrf_addr_r;
    vrf_base_s  = vrf_base_r;
    vrf_wdata_s = vrf_wdata_r;

    case (state_r)
      BURST: begin
        if (!last_s) begin
          beat_s      = beat_nx_s;
          vrf_we_s    = 1'b1;
          vrf_base_s  = LBW'(int'(beat_nx_s) * LPC);
          vrf_wdata_s = buf_r[beat_nx_s];
        end else begin
          state_s = IDLE;
        end
      end
      IDLE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (accept_s && wb.reg_write) begin
      if (wb.is_vec) begin
        buf_load_s  = 1'b1;
        beat_s      = {CW{1'b0}};
        vrf_we_s    = 1'b1;
        vrf_addr_s  = wb.write_addr;
        vrf_base_s  = {LBW{1'b0}};
        vrf_wdata_s = wb.lane_data[BW-1:0];
        state_s     = (BEATS > 1) ? BURST : IDLE;
      end else if (wb.write_addr != {ADDR_W{1'b0}}) begin
        srf_we_s    = 1'b1;
        srf_addr_s  = wb.write_addr;
        srf_wdata_s = wb.mem_to_reg ? wb.read_data : wb.alu_result;
      end else begin
        srf_we_s = 1'b0;
      end
    end else begin
      buf_load_s = 1'b0;
    end
  end

  // State, lane buffer and registered RF write ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      beat_r      <= {CW{1'b0}};
      srf_we_r    <= 1'b0;
      srf_addr_r  <= {ADDR_W{1'b0}};
      srf_wdata_r <= {DATA_W{1'b0}};
      vrf_we_r    <= 1'b0;
      vrf_addr_r  <= {ADDR_W{1'b0}};
      vrf_base_r  <= {LBW{1'b0}};
      vrf_wdata_r <= {BW{1'b0}};
      for (int b = 0; b < BEATS; b++) buf_r[b] <= {BW{1'b0}};
    end else begin
      state_r     <= state_s;
      beat_r      <= beat_s;
      srf_we_r    <= srf_we_s;
      srf_addr_r  <= srf_addr_s;
      srf_wdata_r <= srf_wdata_s;
      vrf_we_r    <= vrf_we_s;
      vrf_addr_r  <= vrf_addr_s;
      vrf_base_r  <= vrf_base_s;
      vrf_wdata_r <= vrf_wdata_s;
      for (int b = 0; b < BEATS; b++) begin
        if (buf_load_s) buf_r[b] <= wb.lane_data[b*BW +: BW];
        else            buf_r[b] <= buf_r[b];
      end
    end
  end

  assign wb.in_ready      = in_ready_s;
  assign wb.srf_we        = srf_we_r;
  assign wb.srf_addr      = srf_addr_r;
  assign wb.srf_wdata     = srf_wdata_r;
  assign wb.vrf_we        = vrf_we_r;
  assign wb.vrf_addr      = vrf_addr_r;
  assign wb.vrf_lane_base = vrf_base_r;
  assign wb.vrf_wdata     = vrf_wdata_r;
  assign wb.busy          = (state_r == BURST);
endmodule

// File: tb/tb_vec_wb_sequencer.sv
// Directed bench for vec_wb_sequencer: scalar writes, r0 suppression, vector bursts, back-to-back, reset.
module tb_vec_wb_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  vec_wb_sequencer_if #(.DATA_W(32), .LANES(8), .LPC(2), .ADDR_W(5)) bus ();

  vec_wb_sequencer #(.DATA_W(32), .LANES(8), .LPC(2), .ADDR_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .wb (bus.slave)
  );

  always #5 clk = ~clk;

  logic [255:0] vec_a;
  logic [255:0] vec_b;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic vec, input logic m2r,
                       input logic [4:0] addr, input logic [31:0] alu, input logic [31:0] rd,
                       input logic [255:0] lanes);
    bus.in_valid   = v;
    bus.reg_write  = rw;
    bus.is_vec     = vec;
    bus.mem_to_reg = m2r;
    bus.write_addr = addr;
    bus.alu_result = alu;
    bus.read_data  = rd;
    bus.lane_data  = lanes;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 256'd0);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      vec_a[k*32 +: 32] = 32'h11 * (k + 1);
      vec_b[k*32 +: 32] = 32'h100 + k;
    end
    idle_in();
    repeat (2) @(negedge clk);
    check_val("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check_val("rst_srf_we", 64'(bus.srf_we), 64'd0);
    check_val("rst_vrf_we", 64'(bus.vrf_we), 64'd0);
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_vrf_wdata", 64'(bus.vrf_wdata), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("idle_in_ready", 64'(bus.in_ready), 64'd1);

    // Scalar writes, alu then load data
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h1234, 32'hDEAD, 256'd0);
    @(negedge clk);
    check_val("s_alu_we", 64'(bus.srf_we), 64'd1);
    check_val("s_alu_addr", 64'(bus.srf_addr), 64'd5);
    check_val("s_alu_data", 64'(bus.srf_wdata), 64'h1234);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'h1234, 32'hDEAD, 256'd0);
    @(negedge clk);
    check_val("s_ld_we", 64'(bus.srf_we), 64'd1);
    check_val("s_ld_data", 64'(bus.srf_wdata), 64'hDEAD);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h5555, 32'h0, 256'd0);
    @(negedge clk);
    check_val("s_r0_we", 64'(bus.srf_we), 64'd0);
    check_val("s_r0_addr_hold", 64'(bus.srf_addr), 64'd5);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'h9999, 32'h0, 256'd0);
    @(negedge clk);
    check_val("nowr_srf_we", 64'(bus.srf_we), 64'd0);
    check_val("nowr_vrf_we", 64'(bus.vrf_we), 64'd0);
    check_val("nowr_in_ready", 64'(bus.in_ready), 64'd1);
    idle_in();
    @(negedge clk);
    check_val("bubble_srf_we", 64'(bus.srf_we), 64'd0);

    // Single vector burst, no follow-on work
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 32'h0, 32'h0, vec_a);
    @(negedge clk);
    idle_in();
    check_val("v_first_wdata", 64'(bus.vrf_wdata), 64'h00000022_00000011);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check_val($sformatf("v_we_%0d", i), 64'(bus.vrf_we), 64'd1);
      check_val($sformatf("v_addr_%0d", i), 64'(bus.vrf_addr), 64'd3);
      check_val($sformatf("v_base_%0d", i), 64'(bus.vrf_lane_base), 64'(2 * i));
      check_val($sformatf("v_wdata_%0d", i), 64'(bus.vrf_wdata), vec_a[i*64 +: 64]);
      check_val($sformatf("v_rdy_%0d", i), 64'(bus.in_ready), (i == 3) ? 64'd1 : 64'd0);
      check_val($sformatf("v_busy_%0d", i), 64'(bus.busy), 64'd1);
    end
    @(negedge clk);
    check_val("v_end_we", 64'(bus.vrf_we), 64'd0);
    check_val("v_end_busy", 64'(bus.busy), 64'd0);
    check_val("v_end_rdy", 64'(bus.in_ready), 64'd1);
    check_val("v_end_addr_hold", 64'(bus.vrf_addr), 64'd3);

    // Vector then scalar held continuously: scalar taken on last beat
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 32'h0, 32'h0, vec_a);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'h77, 32'h0, 256'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check_val($sformatf("vs_vwe_%0d", i), 64'(bus.vrf_we), 64'd1);
      check_val($sformatf("vs_swe_%0d", i), 64'(bus.srf_we), 64'd0);
    end
    @(negedge clk);
    idle_in();
    check_val("vs_srf_we", 64'(bus.srf_we), 64'd1);
    check_val("vs_srf_addr", 64'(bus.srf_addr), 64'd7);
    check_val("vs_srf_data", 64'(bus.srf_wdata), 64'h77);
    check_val("vs_vrf_we", 64'(bus.vrf_we), 64'd0);
    check_val("vs_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check_val("vs_after_swe", 64'(bus.srf_we), 64'd0);

    // Vector then vector: eight consecutive beats
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 32'h0, 32'h0, vec_a);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 32'h0, 32'h0, vec_b);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 4) idle_in();
      check_val($sformatf("vv_we_%0d", i), 64'(bus.vrf_we), 64'd1);
      check_val($sformatf("vv_addr_%0d", i), 64'(bus.vrf_addr), (i < 4) ? 64'd3 : 64'd4);
      check_val($sformatf("vv_base_%0d", i), 64'(bus.vrf_lane_base), 64'(2 * (i % 4)));
      check_val($sformatf("vv_wdata_%0d", i), 64'(bus.vrf_wdata),
                (i < 4) ? vec_a[(i % 4)*64 +: 64] : vec_b[(i % 4)*64 +: 64]);
    end
    @(negedge clk);
    check_val("vv_end_we", 64'(bus.vrf_we), 64'd0);

    // Reset during beat 2 aborts the burst
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 32'h0, 32'h0, vec_a);
    @(negedge clk);
    idle_in();
    @(negedge clk);
    @(negedge clk);
    check_val("r_beat2_base", 64'(bus.vrf_lane_base), 64'd4);
    rst = 1'b1;
    @(negedge clk);
    check_val("r_vrf_we", 64'(bus.vrf_we), 64'd0);
    check_val("r_srf_we", 64'(bus.srf_we), 64'd0);
    check_val("r_busy", 64'(bus.busy), 64'd0);
    check_val("r_in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("r_rel_rdy", 64'(bus.in_ready), 64'd1);
    check_val("r_rel_we", 64'(bus.vrf_we), 64'd0);
    @(negedge clk);
    check_val("r_stale_we", 64'(bus.vrf_we), 64'd0);
    check_val("r_stale_busy", 64'(bus.busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
